// File: rtl/popcount_expander_16.sv
// Expands a 5-bit ones-count into a 16-lane word with exactly that many lanes set.
// A rotating lane pointer spreads the ones; output register plus one skid entry.
module popcount_expander_16 #(
  parameter int unsigned ROTATE = 1,
  parameter int unsigned SEED   = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  sum,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] bits,
  output logic        overflow
);

  logic [3:0]  r_p;
  logic [15:0] r_out;
  logic [15:0] r_skid;
  logic        r_out_v;
  logic        r_skid_v;
  logic        r_in_ready;
  logic        r_ovf;

  logic        w_acc;
  logic        w_drain;
  logic        w_ovf_in;
  logic [4:0]  w_c;
  logic [15:0] w_mask;
  logic [15:0] w_word;
  logic [15:0] w_out_nxt;
  logic [15:0] w_skid_nxt;
  logic        w_out_v_nxt;
  logic        w_skid_v_nxt;

  assign w_acc   = in_valid && r_in_ready;
  assign w_drain = r_out_v && out_ready;

  // Lanes p..p+c-1 (mod 16): a low-aligned mask of c ones rotated left by p.
  always_comb begin
    w_ovf_in = (sum > 5'd16);
    w_c      = w_ovf_in ? 5'd16 : sum;
    w_mask   = 16'hFFFF >> (5'd16 - w_c);
    w_word   = (w_mask << r_p) | (w_mask >> (5'd16 - {1'b0, r_p}));
  end

  always_comb begin
    w_out_nxt    = r_out;
    w_skid_nxt   = r_skid;
    w_out_v_nxt  = r_out_v;
    w_skid_v_nxt = r_skid_v;
    if (r_skid_v) begin
      // in_ready is low whenever SKID is occupied, so no accept can coincide.
      if (w_drain) begin
        w_out_nxt    = r_skid;
        w_skid_v_nxt = 1'b0;
      end
    end else if (w_acc) begin
      if (!r_out_v || w_drain) begin
        w_out_nxt   = w_word;
        w_out_v_nxt = 1'b1;
      end else begin
        w_skid_nxt   = w_word;
        w_skid_v_nxt = 1'b1;
      end
    end else if (w_drain) begin
      w_out_v_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_p        <= 4'(SEED);
      r_out      <= '0;
      r_skid     <= '0;
      r_out_v    <= 1'b0;
      r_skid_v   <= 1'b0;
      r_in_ready <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_out      <= w_out_nxt;
      r_skid     <= w_skid_nxt;
      r_out_v    <= w_out_v_nxt;
      r_skid_v   <= w_skid_v_nxt;
      r_in_ready <= !w_skid_v_nxt;
      if (w_acc && (ROTATE != 0)) begin
        r_p <= r_p + w_c[3:0];
      end
      if (w_acc && w_ovf_in) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_v;
  assign bits      = r_out;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_popcount_expander_16.sv
// Directed bench: three parameterisations checked every cycle against a
// FIFO-of-words model, plus literal expectations on the logged output words.
module tb_popcount_expander_16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iv   [3];
  logic        ir   [3];
  logic [4:0]  sm   [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [15:0] bt   [3];
  logic        of   [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  popcount_expander_16 #(.ROTATE(1), .SEED(0)) u_a (
    .CLK(CLK), .nRST(nRST), .in_valid(iv[0]), .in_ready(ir[0]), .sum(sm[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .bits(bt[0]), .overflow(of[0]));
  popcount_expander_16 #(.ROTATE(0), .SEED(4)) u_b (
    .CLK(CLK), .nRST(nRST), .in_valid(iv[1]), .in_ready(ir[1]), .sum(sm[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .bits(bt[1]), .overflow(of[1]));
  popcount_expander_16 #(.ROTATE(1), .SEED(14)) u_c (
    .CLK(CLK), .nRST(nRST), .in_valid(iv[2]), .in_ready(ir[2]), .sum(sm[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .bits(bt[2]), .overflow(of[2]));

  function automatic int rot_of(input int d);
    return (d == 1) ? 0 : 1;
  endfunction

  function automatic int seed_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 4 : 14);
  endfunction

  function automatic int clamp16(input int s);
    return (s > 16) ? 16 : s;
  endfunction

  function automatic logic [15:0] expand(input int p, input int s);
    logic [15:0] w;
    w = '0;
    for (int i = 0; i < clamp16(s); i++) w[(p + i) % 16] = 1'b1;
    return w;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Model: two-deep FIFO of already-expanded words per DUT.
  logic [15:0] mq [3][4];
  int          mh [3];
  int          mc [3];
  int          mp [3];
  bit          movf [3];
  bit          mst  [3];

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int d = 0; d < 3; d++) begin
        mh[d]   <= 0;
        mc[d]   <= 0;
        mp[d]   <= seed_of(d);
        movf[d] <= 1'b0;
        mst[d]  <= 1'b0;
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        automatic bit pop  = ordy[d] && (mc[d] > 0);
        automatic bit push = iv[d] && mst[d] && (mc[d] < 2);
        if (push) begin
          mq[d][(mh[d] + mc[d]) % 4] <= expand(mp[d], int'(sm[d]));
          if (rot_of(d) != 0) mp[d] <= (mp[d] + clamp16(int'(sm[d]))) % 16;
          if (int'(sm[d]) > 16) movf[d] <= 1'b1;
        end
        mc[d]  <= mc[d] + int'(push) - int'(pop);
        mh[d]  <= pop ? (mh[d] + 1) % 4 : mh[d];
        mst[d] <= 1'b1;
      end
    end
  end

  logic [15:0] lg  [3][32];
  int          lgc [3][32];
  int          ln  [3] = '{0, 0, 0};

  always @(negedge CLK) begin
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("out_valid[%0d]", d), int'(ov[d]), int'(mc[d] > 0));
      chk($sformatf("in_ready[%0d]", d), int'(ir[d]), int'(mst[d] && (mc[d] < 2)));
      chk($sformatf("overflow[%0d]", d), int'(of[d]), int'(movf[d]));
      if (mc[d] > 0) chk($sformatf("bits[%0d]", d), int'(bt[d]), int'(mq[d][mh[d]]));
      if (ov[d] && ordy[d] && nRST && ln[d] < 32) begin
        lg[d][ln[d]]  = bt[d];
        lgc[d][ln[d]] = cyc;
        ln[d]++;
      end
    end
  end

  task automatic send(input int d, input int s);
    bit ok;
    iv[d] = 1'b1;
    sm[d] = 5'(s);
    for (int k = 0; k < 50; k++) begin
      ok = ir[d];
      @(posedge CLK);
      #1;
      if (ok) return;
    end
    checks++;
    errors++;
    $display("FAIL send_timeout[%0d]: got no accept expected accept within 50 cycles", d);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    automatic logic [15:0] exp_a [11] = '{16'h0007, 16'h00F8, 16'h0000, 16'hFFFF, 16'h0100,
                                          16'h0200, 16'h0C00, 16'h7000,
                                          16'hFFFF, 16'h8000, 16'h0001};
    automatic logic [15:0] exp_b [3] = '{16'h0030, 16'h0030, 16'h0010};
    automatic logic [15:0] exp_c [3] = '{16'hC003, 16'h0004, 16'h4000};

    nRST = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; sm[d] = '0; ordy[d] = 1'b1;
    end
    step(3);
    nRST = 1'b1;
    chk("rst_in_ready", int'(ir[0]), 0);
    chk("rst_out_valid", int'(ov[0]), 0);
    chk("rst_bits", int'(bt[0]), 0);
    chk("rst_overflow", int'(of[0]), 0);
    step(1);
    chk("in_ready_rise", int'(ir[0]), 1);

    send(0, 3); send(0, 5); send(0, 0); send(0, 16); send(0, 1);
    iv[0] = 1'b0;
    step(3);

    send(1, 2); send(1, 2);
    iv[1] = 1'b0;
    send(2, 4); send(2, 1);
    iv[2] = 1'b0;
    step(3);

    ordy[0] = 1'b0;
    send(0, 1); send(0, 2);
    iv[0] = 1'b1; sm[0] = 5'd3;
    chk("bp_in_ready_low", int'(ir[0]), 0);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk("bp_held", int'(ir[0]), 0);
    end
    ordy[0] = 1'b1;
    send(0, 3);
    iv[0] = 1'b0;
    step(4);

    send(0, 20);
    iv[0] = 1'b0;
    chk("ovf_set", int'(of[0]), 1);
    send(0, 1);
    iv[0] = 1'b0;
    step(3);
    chk("ovf_sticky", int'(of[0]), 1);

    ordy[0] = 1'b0;
    send(0, 1); send(0, 1);
    iv[0] = 1'b0;
    chk("full_in_ready", int'(ir[0]), 0);
    chk("full_out_valid", int'(ov[0]), 1);
    #2 nRST = 1'b0;
    #1;
    chk("async_out_valid", int'(ov[0]), 0);
    chk("async_in_ready", int'(ir[0]), 0);
    chk("async_overflow", int'(of[0]), 0);
    step(1);
    nRST = 1'b1;
    ordy[0] = 1'b1;
    step(1);
    send(0, 1); iv[0] = 1'b0;
    send(1, 1); iv[1] = 1'b0;
    send(2, 1); iv[2] = 1'b0;
    step(4);

    chk("log_count_a", ln[0], 11);
    chk("log_count_b", ln[1], 3);
    chk("log_count_c", ln[2], 3);
    for (int k = 0; k < 11; k++)
      if (k < ln[0]) chk($sformatf("word_a%0d", k), int'(lg[0][k]), int'(exp_a[k]));
    for (int k = 0; k < 3; k++) begin
      if (k < ln[1]) chk($sformatf("word_b%0d", k), int'(lg[1][k]), int'(exp_b[k]));
      if (k < ln[2]) chk($sformatf("word_c%0d", k), int'(lg[2][k]), int'(exp_c[k]));
    end
    if (ln[0] >= 8) begin
      chk("bp_gap1", lgc[0][6] - lgc[0][5], 1);
      chk("bp_gap2", lgc[0][7] - lgc[0][6], 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1);
  end

endmodule
